zigbee_rx_deframer: RTL and testbench

- Parametrised successor to the RX back-end: takes the CDR bit stream (data plus valid strobe) and finds the IEEE 802.15.4 preamble and SFD.
- Extracts the 7-bit PHR length, packs the payload LSB-first into bytes and buffers them in an internal synchronous FIFO.
- The CPU-side reader drains the FIFO with a 1-cycle read handshake.
- Adds frame-level behaviour: sync search, length checking, gap timeout, overflow drop and frame status pulses.

---
 rtl/zigbee_rx_deframer.sv | 164 ++++++++++++++++
 tb/tb_zigbee_rx_deframer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/zigbee_rx_deframer.sv
// zigbee_rx_deframer: 802.15.4 sync search, PHR/payload byte packing and a byte FIFO toward the CPU.
module zigbee_rx_deframer #(
  parameter int          PREAMBLE_ZEROS = 32,
  parameter logic [7:0]  SFD_VALUE      = 8'hA7,
  parameter int          MAX_LEN        = 127,
  parameter int          FIFO_SIZE_BIT  = 7,
  parameter int          GAP_TIMEOUT    = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_bit,
  input  logic                     i_bit_valid,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic                     o_rd_valid,
  output logic [FIFO_SIZE_BIT:0]   o_level,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_frame_start,
  output logic                     o_frame_done,
  output logic                     o_len_err,
  output logic                     o_abort,
  output logic                     o_overflow,
  output logic [1:0]               o_state
);
  localparam int W = PREAMBLE_ZEROS + 8;
  localparam int DEPTH = 2 ** FIFO_SIZE_BIT;
  localparam int LW = FIFO_SIZE_BIT + 1;
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [1:0] HUNT = 2'd0, PHR = 2'd1, PAYLOAD = 2'd2, DONE = 2'd3;
  localparam logic [W-1:0] SYNC = {SFD_VALUE, {PREAMBLE_ZEROS{1'b0}}};
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  logic [1:0] state_q, state_d;
  logic [W-1:0] sr_q, sr_d, sr_sh;
  logic [7:0] byte_q, byte_d, byte_sh, wr_byte;
  logic [2:0] bcnt_q, bcnt_d;
  logic [6:0] left_q, left_d, len;
  logic [GW-1:0] gap_q, gap_d;
  logic start_q, start_d, len_err_q, len_err_d, abort_q, abort_d, ovf_q;
  logic wr_req, wr_acc, rd_acc, timeout, len_bad;
  logic [7:0] mem [DEPTH];
  logic [FIFO_SIZE_BIT-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q, level_d;
  logic empty_q, full_q, rd_valid_q;
  logic [7:0] rd_data_q;
  assign sr_sh = W'({i_bit, sr_q} >> 1);
  assign byte_sh = 8'({i_bit, byte_q} >> 1);
  assign len = byte_sh[6:0];
  assign len_bad = len == 7'd0 || int'(len) > MAX_LEN;
  assign timeout = !i_bit_valid && gap_q == GW'(GAP_TIMEOUT - 1);
  always_ff @(posedge i_clk)
    state_q <= i_rst ? HUNT : state_d;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    byte_d = byte_q;
    bcnt_d = bcnt_q;
    left_d = left_q;
    gap_d = i_bit_valid ? '0 : gap_q + GW'(1);
    start_d = 1'b0;
    len_err_d = 1'b0;
    abort_d = 1'b0;
    wr_req = 1'b0;
    wr_byte = byte_sh;
    case (state_q)
      HUNT: begin
        gap_d = '0;
        bcnt_d = '0;
        if (i_bit_valid) begin
          sr_d = sr_sh;
          if (sr_sh == SYNC) begin
            state_d = PHR;
            start_d = 1'b1;
          end
        end
      end
      PHR, PAYLOAD: begin
        if (timeout) begin
          state_d = HUNT;
          sr_d = '0;
          abort_d = 1'b1;
        end else if (i_bit_valid) begin
          byte_d = byte_sh;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7 && state_q == PHR) begin
            state_d = len_bad ? HUNT : PAYLOAD;
            sr_d = len_bad ? '0 : sr_q;
            len_err_d = len_bad;
            wr_req = !len_bad;
            wr_byte = {1'b0, len};
            left_d = len;
          end else if (bcnt_q == 3'd7) begin
            wr_req = 1'b1;
            left_d = left_q - 7'd1;
            state_d = left_q == 7'd1 ? DONE : PAYLOAD;
          end
        end
      end
      default: begin
        state_d = HUNT;
        sr_d = '0;
      end
    endcase
  end
  always_comb begin
    o_state = state_q;
    o_frame_done = state_q == DONE;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sr_q <= '0;
      byte_q <= '0;
      bcnt_q <= '0;
      left_q <= '0;
      gap_q <= '0;
      start_q <= 1'b0;
      len_err_q <= 1'b0;
      abort_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      byte_q <= byte_d;
      bcnt_q <= bcnt_d;
      left_q <= left_d;
      gap_q <= gap_d;
      start_q <= start_d;
      len_err_q <= len_err_d;
      abort_q <= abort_d;
      ovf_q <= wr_req && !wr_acc;
    end
  // a read from a full FIFO frees its slot in the same cycle, so the write lands
  assign rd_acc = i_rd_en && !empty_q;
  assign wr_acc = wr_req && (!full_q || rd_acc);
  assign level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
  always_ff @(posedge i_clk)
    if (wr_acc) mem[wp_q] <= wr_byte;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wp_q <= wp_q + FIFO_SIZE_BIT'(wr_acc);
      rp_q <= rp_q + FIFO_SIZE_BIT'(rd_acc);
      level_q <= level_d;
      empty_q <= level_d == '0;
      full_q <= level_d == FULL_LVL;
      rd_data_q <= rd_acc ? mem[rp_q] : rd_data_q;
      rd_valid_q <= rd_acc;
    end
  assign o_rd_data = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_level = level_q;
  assign o_empty = empty_q;
  assign o_full = full_q;
  assign o_frame_start = start_q;
  assign o_len_err = len_err_q;
  assign o_abort = abort_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_zigbee_rx_deframer.sv
// tb_zigbee_rx_deframer: directed frames into a default DUT and a 4-deep FIFO DUT sharing the bit stream.
module tb_zigbee_rx_deframer;
  logic clk, rst, bit_i, vld, rd_en, rd_en_s;
  logic [7:0] rd_data, rd_data_s;
  logic [7:0] level;
  logic [2:0] level_s;
  logic rd_valid, empty, full, fstart, fdone, lerr, abrt, ovf;
  logic rd_valid_s, empty_s, full_s, fstart_s, fdone_s, lerr_s, abrt_s, ovf_s;
  logic [1:0] state, state_s;
  int n_chk = 0, n_err = 0;
  int n_start, n_done, n_lerr, n_abort, n_ovf, s_done, s_ovf;
  int n;
  logic [7:0] byte_v;
  zigbee_rx_deframer dut (
    .i_clk(clk), .i_rst(rst), .i_bit(bit_i), .i_bit_valid(vld), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_level(level), .o_empty(empty), .o_full(full),
    .o_frame_start(fstart), .o_frame_done(fdone), .o_len_err(lerr), .o_abort(abrt),
    .o_overflow(ovf), .o_state(state)
  );
  zigbee_rx_deframer #(.FIFO_SIZE_BIT(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_bit(bit_i), .i_bit_valid(vld), .i_rd_en(rd_en_s),
    .o_rd_data(rd_data_s), .o_rd_valid(rd_valid_s), .o_level(level_s), .o_empty(empty_s), .o_full(full_s),
    .o_frame_start(fstart_s), .o_frame_done(fdone_s), .o_len_err(lerr_s), .o_abort(abrt_s),
    .o_overflow(ovf_s), .o_state(state_s)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst) begin
      n_start = 0; n_done = 0; n_lerr = 0; n_abort = 0; n_ovf = 0; s_done = 0; s_ovf = 0;
    end else begin
      n_start += int'(fstart); n_done += int'(fdone); n_lerr += int'(lerr);
      n_abort += int'(abrt); n_ovf += int'(ovf); s_done += int'(fdone_s); s_ovf += int'(ovf_s);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic b, input logic rd);
    bit_i = b; vld = 1'b1; rd_en_s = rd;
    @(posedge clk); #1;
    vld = 1'b0; rd_en_s = 1'b0;
  endtask
  task automatic send_bit(input logic b);
    strobe(b, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask
  task automatic send_sync();
    repeat (32) send_bit(1'b0);
    send_byte(8'hA7);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic rd(input logic [7:0] exp);
    rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 1);
    chk("rd_data", 32'(rd_data), 32'(exp));
  endtask
  task automatic rd_s(input logic [7:0] exp);
    rd_en_s = 1'b1;
    @(posedge clk); #1 rd_en_s = 1'b0;
    chk("rd_s_valid", 32'(rd_valid_s), 1);
    chk("rd_s_data", 32'(rd_data_s), 32'(exp));
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; bit_i = 1'b0; vld = 1'b0; rd_en = 1'b0; rd_en_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_pulses", 32'({fstart, fdone, lerr, abrt, ovf}), 0);
    send_sync();
    chk("sync_state", 32'(state), 1);
    chk("sync_start", n_start, 1);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("f1_done", n_done, 1);
    chk("f1_level", 32'(level), 4);
    chk("f1_state", 32'(state), 0);
    rd(8'h03); rd(8'h11); rd(8'h22); rd(8'h33);
    chk("f1_empty", 32'(empty), 1);
    rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    chk("rd_when_empty", 32'(rd_valid), 0);
    repeat (8) send_bit(1'b1);
    repeat (31) send_bit(1'b0);
    send_byte(8'hA7);
    chk("miss31_state", 32'(state), 0);
    repeat (32) send_bit(1'b0);
    send_byte(8'hA6);
    chk("missA6_state", 32'(state), 0);
    chk("miss_start", n_start, 1);
    chk("miss_level", 32'(level), 0);
    send_sync(); send_byte(8'h00);
    chk("len00_err", n_lerr, 1);
    chk("len00_state", 32'(state), 0);
    send_sync(); send_byte(8'h80);
    chk("len80_err", n_lerr, 2);
    chk("len80_state", 32'(state), 0);
    chk("len_level", 32'(level), 0);
    send_sync(); send_byte(8'h81); send_byte(8'h5A);
    chk("phr_b7_done", n_done, 2);
    rd(8'h01); rd(8'h5A);
    do_reset();
    send_sync(); send_byte(8'h06);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    chk("ovf_level", 32'(level_s), 4);
    chk("ovf_full", 32'(full_s), 1);
    chk("ovf_cnt", s_ovf, 3);
    chk("ovf_done", s_done, 1);
    chk("ovf_main_level", 32'(level), 7);
    chk("ovf_main_none", n_ovf, 0);
    do_reset();
    send_sync(); send_byte(8'h05); send_byte(8'hA1); send_byte(8'hA2);
    n = 3;
    while (!abrt && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gap_cycles", n, 1024);
    chk("gap_level", 32'(level), 3);
    chk("gap_state", 32'(state), 0);
    send_sync(); send_byte(8'h01); send_byte(8'h77);
    chk("gap_abort_cnt", n_abort, 1);
    chk("gap_next_done", n_done, 1);
    chk("gap_next_level", 32'(level), 5);
    rd(8'h05); rd(8'hA1); rd(8'hA2); rd(8'h01); rd(8'h77);
    do_reset();
    send_sync(); send_byte(8'h05); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    chk("sim_full", 32'(full_s), 1);
    byte_v = 8'h40;
    for (int i = 0; i < 7; i++) send_bit(byte_v[i]);
    strobe(byte_v[7], 1'b1);
    chk("sim_level", 32'(level_s), 4);
    chk("sim_ovf_pulse", 32'(ovf_s), 0);
    chk("sim_rd_valid", 32'(rd_valid_s), 1);
    chk("sim_rd_data", 32'(rd_data_s), 32'h05);
    repeat (3) @(posedge clk);
    #1;
    chk("sim_ovf_cnt", s_ovf, 0);
    send_byte(8'h50);
    chk("sim_ovf_after", s_ovf, 1);
    chk("sim_done", s_done, 1);
    rd_s(8'h10); rd_s(8'h20); rd_s(8'h30); rd_s(8'h40);
    chk("sim_empty", 32'(empty_s), 1);
    do_reset();
    send_sync(); send_byte(8'h03); send_byte(8'h11);
    chk("mid_state", 32'(state), 2);
    chk("mid_level", 32'(level), 2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_level", 32'(level), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
